dac_spi_scheduler: RTL and testbench
====================================

# dac_spi_scheduler

Shares one SPI bus between the two DAC channel words produced by the square/wave datapath. On each 50 kHz sampling tick it latches both 12-bit channel words and sends one 16-bit MCP4922-style frame per enabled channel, A first. It then pulses LDAC so both DAC outputs update on the same edge. It sits between the wave-generation datapath and the DAC pins.

## Interface
- CLK_DIV, 5: clk cycles per SCK half-period, and the unit for all setup, hold and gap intervals; legal range ≥2.
- CFG_BITS, 3'b111: frame bits [14:12] = {BUF, GA_n, SHDN_n}.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- clk_sampling  in  1  one-cycle sampling tick at 50 kHz.
- enableA  in  1  send the channel A frame this tick.
- enableB  in  1  send the channel B frame this tick.
- dacA_word  in  12  channel A code, sampled on the tick.
- dacB_word  in  12  channel B code, sampled on the tick.
- spi_cs_n  out  1  DAC chip select, active low.
- spi_sck  out  1  SPI clock, mode 0.
- spi_mosi  out  1  serial data, MSB first.
- ldac_n  out  1  DAC latch strobe, active low.
- busy  out  1  high from the cycle after an accepted tick until return to IDLE.
- overrun  out  1  one-cycle pulse when a tick arrives while busy.
- overrun_sticky  out  1  set by overrun, cleared only by rst.

## Operation
- Frame format: bit15 = channel select (0 = A, 1 = B); bits [14:12] = CFG_BITS; bits [11:0] = word.
- On a tick in IDLE with at least one enable high:
  - latch both words and both enables into registers.
  - later input changes do not affect the transfer in progress.
- On a tick in IDLE with both enables low: nothing happens; no frames, no LDAC pulse, busy stays low.
- States and transitions:
  - IDLE → CS_SETUP on an accepted tick.
  - CS_SETUP (cs_n low, sck low) for CLK_DIV cycles → SHIFT.
  - SHIFT sends 16 bits. For each bit: MOSI is driven at the start of the bit, sck is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SHIFT → CS_HOLD (sck low, cs_n low) for CLK_DIV cycles → GAP (cs_n high) for CLK_DIV cycles.
  - After GAP: go to CS_SETUP for channel B if B is latched enabled and not yet sent; otherwise go to LDAC.
  - LDAC (ldac_n low) for CLK_DIV cycles → IDLE.
- Channel order is A then B. A disabled channel is skipped. A single enabled channel produces one frame followed by LDAC.
- A tick while not in IDLE:
  - is dropped; the transfer in progress is unaffected.
  - overrun pulses; overrun_sticky sets.
- rst, including mid-frame: returns to IDLE on the next edge, clears all latched data and overrun_sticky, and drops the partial frame.
- spi_mosi is 0 whenever cs_n is high.

## Timing
- All outputs are registered.
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, ldac_n=1, busy=0, overrun=0, overrun_sticky=0.
- Tick sampled high at edge T:
  - spi_cs_n falls at T+1.
  - busy rises at T+1.
  - The first sck rising edge is at T+1+2·CLK_DIV.
- Frame length (cs_n low) is 34·CLK_DIV cycles. Each frame is followed by a CLK_DIV gap.
- Both channels enabled: busy is high for 71·CLK_DIV cycles (355 at default). This is well inside the 20 µs tick period at 100 MHz clk.
- ldac_n is low for exactly CLK_DIV cycles. It starts CLK_DIV cycles after the last cs_n rise.
- A tick on the same edge that busy falls is accepted; it is not an overrun.
- A tick and rst on the same edge: rst wins.

## Structure
- wavegen_pkg holds:
  - the state enum {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LDAC}.
  - FRAME_W=16.
  - the channel-select constants CH_A=1'b0 and CH_B=1'b1.
  - the default CFG_BITS.
- Sub-module spi_shift16 handles loading a frame, the divider, sck generation and the bit counter. Inputs: start and frame. Outputs: done, sck, mosi.
- The top level owns the scheduler FSM, the latches and the overrun logic.

## Test plan
- Reset and idle:
  - Stimulus: rst high for 3 cycles, then idle for 100 cycles.
  - Response: all outputs hold their reset values.
- Both channels enabled:
  - Stimulus: tick with dacA_word=12'h800, dacB_word=12'h3FF, CLK_DIV=5.
  - Response: the bench decodes frames 16'h7800 then 16'hF3FF; ldac_n is low for 5 cycles; busy lasts 355 cycles.
- Only channel B enabled:
  - Stimulus: tick with enableA=0, dacB_word=12'hABC.
  - Response: exactly one frame, 16'hFABC, then LDAC; busy lasts 36·CLK_DIV cycles.
- Overrun:
  - Stimulus: a second tick 50 cycles after an accepted tick.
  - Response: overrun pulses for 1 cycle; overrun_sticky=1; frames are unchanged; no extra transfer.
- Reset mid-operation:
  - Stimulus: rst during bit 7 of frame A.
  - Response: next cycle cs_n=1 and sck=0; no LDAC pulse; the next tick starts a clean full sequence.
- Inputs changed during a transfer:
  - Stimulus: change dacA_word to 12'h123 at cycle T+20.
  - Response: the transmitted frame still carries the value latched on the tick.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared types and constants for the wave-generation DAC output path.
package wavegen_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LDAC} state_t;

  localparam int         FRAME_W          = 16;
  localparam logic       CH_A             = 1'b0;
  localparam logic       CH_B             = 1'b1;
  localparam logic [2:0] DEFAULT_CFG_BITS = 3'b111;
endpackage

// File: rtl/spi_shift16.sv
// Mode-0 SPI shifter: sends one frame MSB first, CLK_DIV cycles per SCK half-period.
module spi_shift16
  import wavegen_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               done,
  output logic               sck,
  output logic               mosi
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_W);

  logic               r_active;
  logic               r_phase;
  logic [DW-1:0]      r_div;
  logic [BW-1:0]      r_bit;
  logic [FRAME_W-1:0] r_shreg;
  logic               r_sck;
  logic               r_mosi;
  logic               w_half_end;

  assign w_half_end = (r_div == DW'(CLK_DIV - 1));
  // done marks the final cycle of the last high half, so the caller leaves SHIFT in step
  assign done       = r_active & r_phase & w_half_end & (r_bit == BW'(FRAME_W - 1));
  assign sck        = r_sck;
  assign mosi       = r_mosi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
    end else begin
      r_sck  <= r_active & r_phase;
      r_mosi <= r_active & r_shreg[FRAME_W-1];
      if (start) begin
        r_active <= 1'b1;
        r_phase  <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        r_shreg  <= frame;
      end else if (r_active) begin
        if (w_half_end) begin
          r_div   <= '0;
          r_phase <= ~r_phase;
          if (r_phase) begin
            if (r_bit == BW'(FRAME_W - 1)) begin
              r_active <= 1'b0;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dac_spi_scheduler.sv
// Per-tick scheduler sharing one SPI bus between DAC channels A and B, then pulsing LDAC.
module dac_spi_scheduler
  import wavegen_pkg::*;
#(
  parameter int         CLK_DIV  = 5,
  parameter logic [2:0] CFG_BITS = DEFAULT_CFG_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_sampling,
  input  logic        enableA,
  input  logic        enableB,
  input  logic [11:0] dacA_word,
  input  logic [11:0] dacB_word,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        ldac_n,
  output logic        busy,
  output logic        overrun,
  output logic        overrun_sticky
);
  localparam int CW = $clog2(CLK_DIV);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               w_cnt_end;
  logic               w_accept;
  logic               w_start;
  logic               w_done;
  logic               w_tick_busy;
  logic               r_en_b;
  logic               r_chan;
  logic [11:0]        r_word_a;
  logic [11:0]        r_word_b;
  logic [FRAME_W-1:0] w_frame;
  logic               r_cs_n;
  logic               r_ldac_n;
  logic               r_busy;
  logic               r_overrun;
  logic               r_sticky;

  assign w_cnt_end   = (r_cnt == CW'(CLK_DIV - 1));
  assign w_accept    = clk_sampling & (r_state == IDLE) & (enableA | enableB);
  assign w_tick_busy = clk_sampling & (r_state != IDLE);
  assign w_frame     = {r_chan, CFG_BITS, (r_chan == CH_B) ? r_word_b : r_word_a};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state != IDLE && r_state != SHIFT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE:     if (w_accept) w_next = CS_SETUP;
      CS_SETUP: if (w_cnt_end) begin
                  w_next  = SHIFT;
                  w_start = 1'b1;
                end
      SHIFT:    if (w_done) w_next = CS_HOLD;
      CS_HOLD:  if (w_cnt_end) w_next = GAP;
      GAP:      if (w_cnt_end) w_next = (r_chan == CH_A && r_en_b) ? CS_SETUP : LDAC;
      LDAC:     if (w_cnt_end) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Words and enables are captured once per accepted tick; r_chan selects the frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_b   <= 1'b0;
      r_chan   <= CH_A;
      r_word_a <= '0;
      r_word_b <= '0;
    end else if (w_accept) begin
      r_en_b   <= enableB;
      r_chan   <= enableA ? CH_A : CH_B;
      r_word_a <= dacA_word;
      r_word_b <= dacB_word;
    end else if (r_state == GAP && w_next == CS_SETUP) begin
      r_chan <= CH_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n    <= 1'b1;
      r_ldac_n  <= 1'b1;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_cs_n    <= !(r_state == CS_SETUP || r_state == SHIFT || r_state == CS_HOLD);
      r_ldac_n  <= (r_state != LDAC);
      r_busy    <= (r_state != IDLE);
      r_overrun <= w_tick_busy;
      r_sticky  <= r_sticky | w_tick_busy;
    end
  end

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .frame (w_frame),
    .done  (w_done),
    .sck   (spi_sck),
    .mosi  (spi_mosi)
  );

  assign spi_cs_n       = r_cs_n;
  assign ldac_n         = r_ldac_n;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign overrun_sticky = r_sticky;
endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Bench for dac_spi_scheduler: decodes the SPI pins and checks against spec-derived timing.
module tb_dac_spi_scheduler;
  localparam int D = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_sampling = 1'b0;
  logic        enableA = 1'b0;
  logic        enableB = 1'b0;
  logic [11:0] dacA_word = '0;
  logic [11:0] dacB_word = '0;
  logic        spi_cs_n, spi_sck, spi_mosi, ldac_n, busy, overrun, overrun_sticky;

  dac_spi_scheduler #(.CLK_DIV(D), .CFG_BITS(3'b111)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_sampling   (clk_sampling),
    .enableA        (enableA),
    .enableB        (enableB),
    .dacA_word      (dacA_word),
    .dacB_word      (dacB_word),
    .spi_cs_n       (spi_cs_n),
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi),
    .ldac_n         (ldac_n),
    .busy           (busy),
    .overrun        (overrun),
    .overrun_sticky (overrun_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Pin-level monitor, sampled on the falling edge
  logic [15:0] frame_q[$];
  int nbits_q[$], cs_fall_q[$], cs_rise_q[$], sck_first_q[$];
  int ldac_fall_q[$], ldac_rise_q[$], busy_rise_q[$], busy_fall_q[$], ov_q[$];
  int idle_viol = 0;
  logic clr = 1'b0;
  logic p_cs = 1'b1, p_sck = 1'b0, p_busy = 1'b0, p_ldac = 1'b1;
  logic [15:0] sh = '0;
  int nb = 0;

  always @(negedge clk) begin
    if (clr) begin
      frame_q.delete(); nbits_q.delete(); cs_fall_q.delete(); cs_rise_q.delete();
      sck_first_q.delete(); ldac_fall_q.delete(); ldac_rise_q.delete();
      busy_rise_q.delete(); busy_fall_q.delete(); ov_q.delete();
      idle_viol = 0;
    end
    if (p_cs && !spi_cs_n) begin cs_fall_q.push_back(cyc); sh = '0; nb = 0; end
    if (!spi_cs_n && spi_sck && !p_sck) begin
      if (nb == 0) sck_first_q.push_back(cyc);
      sh = {sh[14:0], spi_mosi};
      nb++;
    end
    if (!p_cs && spi_cs_n) begin frame_q.push_back(sh); nbits_q.push_back(nb); cs_rise_q.push_back(cyc); end
    if (spi_cs_n && (spi_mosi || spi_sck)) idle_viol++;
    if (!p_busy && busy) busy_rise_q.push_back(cyc);
    if (p_busy && !busy) busy_fall_q.push_back(cyc);
    if (p_ldac && !ldac_n) ldac_fall_q.push_back(cyc);
    if (!p_ldac && ldac_n) ldac_rise_q.push_back(cyc);
    if (overrun) ov_q.push_back(cyc);
    p_cs = spi_cs_n; p_sck = spi_sck; p_busy = busy; p_ldac = ldac_n;
  end

  task automatic clear_mon();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
  endtask

  // Returns in t the clock edge number on which the tick is sampled
  task automatic drive_tick(input logic ea, input logic eb, input logic [11:0] wa,
                            input logic [11:0] wb, output int t);
    @(negedge clk);
    enableA = ea; enableB = eb; dacA_word = wa; dacB_word = wb; clk_sampling = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    clk_sampling = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({spi_cs_n, spi_sck, spi_mosi, ldac_n, busy, overrun, overrun_sticky} !== 7'b1001000) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got %b want 1001000", cyc,
                 {spi_cs_n, spi_sck, spi_mosi, ldac_n, busy, overrun, overrun_sticky});
      end
    end
  endtask

  task automatic test_transfer(input logic ea, input logic eb, input logic [11:0] wa,
                               input logic [11:0] wb, input string nm);
    logic [15:0] exp_q[$];
    int t, n, obs;
    if (ea) exp_q.push_back({1'b0, 3'b111, wa});
    if (eb) exp_q.push_back({1'b1, 3'b111, wb});
    n = exp_q.size();
    clear_mon();
    drive_tick(ea, eb, wa, wb, t);
    enableA = 1'($urandom); enableB = 1'($urandom);
    dacA_word = 12'($urandom); dacB_word = 12'($urandom);
    repeat (75 * D) @(negedge clk);
    n_cmp++;
    if (frame_q.size() != n) begin
      n_err++; $display("FAIL %s frame_count: got %0d want %0d", nm, frame_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      obs = (i < frame_q.size()) ? int'(frame_q[i]) : -1;
      n_cmp++;
      if (obs != int'(exp_q[i])) begin
        n_err++; $display("FAIL %s frame%0d: got %0h want %0h", nm, i, obs, exp_q[i]);
      end
      obs = (i < nbits_q.size()) ? nbits_q[i] : -1;
      n_cmp++;
      if (obs != 16) begin
        n_err++; $display("FAIL %s bits%0d: got %0d want 16", nm, i, obs);
      end
      obs = (i < cs_fall_q.size()) ? cs_fall_q[i] : -1;
      n_cmp++;
      if (obs != t + 1 + 35 * D * i) begin
        n_err++; $display("FAIL %s cs_fall%0d: got %0d want %0d", nm, i, obs, t + 1 + 35 * D * i);
      end
      obs = (i < cs_rise_q.size() && i < cs_fall_q.size()) ? cs_rise_q[i] - cs_fall_q[i] : -1;
      n_cmp++;
      if (obs != 34 * D) begin
        n_err++; $display("FAIL %s cs_low_len%0d: got %0d want %0d", nm, i, obs, 34 * D);
      end
    end
    obs = (sck_first_q.size() > 0) ? sck_first_q[0] : -1;
    n_cmp++;
    if (obs != t + 1 + 2 * D) begin
      n_err++; $display("FAIL %s first_sck: got %0d want %0d", nm, obs, t + 1 + 2 * D);
    end
    obs = (ldac_fall_q.size() == 1) ? ldac_fall_q[0] : -1;
    n_cmp++;
    if (obs != t + 1 + 35 * D * n) begin
      n_err++; $display("FAIL %s ldac_start: got %0d want %0d", nm, obs, t + 1 + 35 * D * n);
    end
    obs = (ldac_fall_q.size() == 1 && ldac_rise_q.size() == 1) ? ldac_rise_q[0] - ldac_fall_q[0] : -1;
    n_cmp++;
    if (obs != D) begin
      n_err++; $display("FAIL %s ldac_len: got %0d want %0d", nm, obs, D);
    end
    obs = (busy_rise_q.size() == 1) ? busy_rise_q[0] : -1;
    n_cmp++;
    if (obs != t + 1) begin
      n_err++; $display("FAIL %s busy_rise: got %0d want %0d", nm, obs, t + 1);
    end
    obs = (busy_rise_q.size() == 1 && busy_fall_q.size() == 1) ? busy_fall_q[0] - busy_rise_q[0] : -1;
    n_cmp++;
    if (obs != (35 * n + 1) * D) begin
      n_err++; $display("FAIL %s busy_len: got %0d want %0d", nm, obs, (35 * n + 1) * D);
    end
    n_cmp++;
    if (idle_viol != 0 || ov_q.size() != 0) begin
      n_err++; $display("FAIL %s idle_pins_overrun: got %0d/%0d want 0/0", nm, idle_viol, ov_q.size());
    end
  endtask

  task automatic test_random(input int iters);
    int en;
    for (int k = 0; k < iters; k++) begin
      en = int'($urandom_range(1, 3));
      test_transfer(en[1], en[0], 12'($urandom), 12'($urandom), "random");
    end
  endtask

  task automatic test_both_low();
    int t;
    clear_mon();
    drive_tick(1'b0, 1'b0, 12'($urandom), 12'($urandom), t);
    repeat (40 * D) @(negedge clk);
    n_cmp++;
    if (busy_rise_q.size() != 0 || frame_q.size() != 0 || ldac_fall_q.size() != 0) begin
      n_err++;
      $display("FAIL both_low: got busy %0d frames %0d ldac %0d want 0 0 0",
               busy_rise_q.size(), frame_q.size(), ldac_fall_q.size());
    end
  endtask

  task automatic test_input_change();
    int t, obs;
    logic [11:0] wa, wb;
    do wa = 12'($urandom); while (wa == 12'h123);
    wb = 12'($urandom);
    clear_mon();
    drive_tick(1'b1, 1'b1, wa, wb, t);
    while (cyc < t + 20) @(negedge clk);
    dacA_word = 12'h123; dacB_word = ~wb; enableA = 1'b0; enableB = 1'b0;
    repeat (75 * D) @(negedge clk);
    obs = (frame_q.size() == 2) ? int'(frame_q[0]) : -1;
    n_cmp++;
    if (obs != int'({4'h7, wa})) begin
      n_err++; $display("FAIL input_change frameA: got %0h want %0h", obs, {4'h7, wa});
    end
    obs = (frame_q.size() == 2) ? int'(frame_q[1]) : -1;
    n_cmp++;
    if (obs != int'({4'hF, wb})) begin
      n_err++; $display("FAIL input_change frameB: got %0h want %0h", obs, {4'hF, wb});
    end
  endtask

  task automatic test_overrun();
    int t, t2, obs;
    logic [11:0] wa, wb;
    wa = 12'($urandom); wb = 12'($urandom);
    clear_mon();
    drive_tick(1'b1, 1'b1, wa, wb, t);
    while (cyc < t + 48) @(negedge clk);
    drive_tick(1'b1, 1'b1, 12'($urandom), 12'($urandom), t2);
    repeat (75 * D) @(negedge clk);
    obs = (ov_q.size() == 1) ? ov_q[0] : -1;
    n_cmp++;
    if (obs != t2 && obs != t2 + 1) begin
      n_err++; $display("FAIL overrun_pulse: got %0d (count %0d) want %0d", obs, ov_q.size(), t2);
    end
    n_cmp++;
    if (overrun_sticky !== 1'b1) begin
      n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun_sticky);
    end
    n_cmp++;
    if (frame_q.size() != 2 || frame_q[0] !== {4'h7, wa} || frame_q[1] !== {4'hF, wb}) begin
      n_err++; $display("FAIL overrun_frames: got count %0d want %0h %0h", frame_q.size(), {4'h7, wa}, {4'hF, wb});
    end
    obs = (busy_rise_q.size() == 1 && busy_fall_q.size() == 1) ? busy_fall_q[0] - busy_rise_q[0] : -1;
    n_cmp++;
    if (obs != 71 * D || ldac_fall_q.size() != 1) begin
      n_err++; $display("FAIL overrun_no_extra: got busy %0d ldac %0d want %0d 1", obs, ldac_fall_q.size(), 71 * D);
    end
  endtask

  task automatic test_reset_mid();
    int t, r;
    clear_mon();
    drive_tick(1'b1, 1'b1, 12'($urandom), 12'($urandom), t);
    r = t + 1 + 15 * D + 2;
    while (cyc < r - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0 || overrun_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_pins: got cs_n %b sck %b busy %b sticky %b want 1 0 0 0",
               spi_cs_n, spi_sck, busy, overrun_sticky);
    end
    repeat (75 * D) @(negedge clk);
    n_cmp++;
    if (ldac_fall_q.size() != 0 || frame_q.size() != 1 || (frame_q.size() == 1 && nbits_q[0] == 16)) begin
      n_err++;
      $display("FAIL reset_mid_dropped: got ldac %0d frames %0d want 0 1(partial)", ldac_fall_q.size(), frame_q.size());
    end
    test_transfer(1'b1, 1'b1, 12'($urandom), 12'($urandom), "after_reset");
  endtask

  task automatic test_back_to_back();
    int t, t2, e, obs;
    logic [11:0] wa2, wb2;
    wa2 = 12'($urandom); wb2 = 12'($urandom);
    clear_mon();
    drive_tick(1'b1, 1'b1, 12'($urandom), 12'($urandom), t);
    e = t + 1 + 71 * D;
    while (cyc < e - 2) @(negedge clk);
    drive_tick(1'b1, 1'b1, wa2, wb2, t2);
    repeat (75 * D) @(negedge clk);
    n_cmp++;
    if (ov_q.size() != 0 || t2 != e) begin
      n_err++; $display("FAIL b2b_overrun: got %0d pulses at edge %0d want 0 at %0d", ov_q.size(), t2, e);
    end
    obs = (busy_rise_q.size() == 2) ? busy_rise_q[1] : -1;
    n_cmp++;
    if (obs != e + 1) begin
      n_err++; $display("FAIL b2b_busy_rise: got %0d want %0d", obs, e + 1);
    end
    n_cmp++;
    if (frame_q.size() != 4 || frame_q[2] !== {4'h7, wa2} || frame_q[3] !== {4'hF, wb2}) begin
      n_err++; $display("FAIL b2b_frames: got count %0d want 4 ending %0h %0h", frame_q.size(), {4'h7, wa2}, {4'hF, wb2});
    end
  endtask

  initial begin
    test_reset();
    test_transfer(1'b1, 1'b1, 12'h800, 12'h3FF, "both");
    test_transfer(1'b0, 1'b1, 12'($urandom), 12'hABC, "only_b");
    test_transfer(1'b1, 1'b0, 12'($urandom), 12'($urandom), "only_a");
    test_random(6);
    test_both_low();
    test_input_change();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
